// File: rtl/keyboard_pad_input.sv
// PS/2 scan-code decoder: turns make/break byte sequences into per-player pad
// commands (last-pressed-wins on up+down conflicts), a start pulse and an error pulse.
module keyboard_pad_input #(
  parameter int unsigned TIMEOUT_CYCLES = 130000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       left_up,
  output logic       left_down,
  output logic       right_up,
  output logic       right_down,
  output logic       start_pulse,
  output logic       seq_error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_W     = 8'h1D;
  localparam logic [7:0] CODE_S     = 8'h1B;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_SPACE = 8'h29;

  localparam logic PRI_UP   = 1'b0;
  localparam logic PRI_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_q, lu_d, ld_q, ld_d, ru_q, ru_d, rd_q, rd_d, sp_q, sp_d;
  logic             pri_l_q, pri_l_d, pri_r_q, pri_r_d;
  logic             left_up_q, left_up_d, left_down_q, left_down_d;
  logic             right_up_q, right_up_d, right_down_q, right_down_d;
  logic             start_q, start_d, err_q, err_d;

  logic             key_ev, key_make, key_ext;

  // Sequence tracker: prefix bytes, final-byte key events, timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    key_ev   = 1'b0;
    key_make = 1'b0;
    key_ext  = 1'b0;
    if (rx_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == CODE_EXT)      state_d = ST_EXT;
          else if (rx_data == CODE_BRK) state_d = ST_BRK;
          else begin
            key_ev   = 1'b1;
            key_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == CODE_BRK)      state_d = ST_EXT_BRK;
          else if (rx_data != CODE_EXT) begin
            key_ev   = 1'b1;
            key_make = 1'b1;
            key_ext  = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (rx_data == CODE_EXT || rx_data == CODE_BRK) err_d = 1'b1;
          else begin
            key_ev  = 1'b1;
            key_ext = (state_q == ST_EXT_BRK);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Held flags and priority; priority only moves on a fresh press.
  always_comb begin
    lu_d    = lu_q;
    ld_d    = ld_q;
    ru_d    = ru_q;
    rd_d    = rd_q;
    sp_d    = sp_q;
    pri_l_d = pri_l_q;
    pri_r_d = pri_r_q;
    start_d = 1'b0;
    if (key_ev) begin
      case ({key_ext, rx_data})
        {1'b0, CODE_W}: begin
          if (key_make && !lu_q) pri_l_d = PRI_UP;
          lu_d = key_make;
        end
        {1'b0, CODE_S}: begin
          if (key_make && !ld_q) pri_l_d = PRI_DOWN;
          ld_d = key_make;
        end
        {1'b1, CODE_UP}: begin
          if (key_make && !ru_q) pri_r_d = PRI_UP;
          ru_d = key_make;
        end
        {1'b1, CODE_DOWN}: begin
          if (key_make && !rd_q) pri_r_d = PRI_DOWN;
          rd_d = key_make;
        end
        {1'b0, CODE_SPACE}: begin
          start_d = key_make && !sp_q;
          sp_d    = key_make;
        end
        default: ;
      endcase
    end
    left_up_d    = lu_d & (~ld_d | (pri_l_d == PRI_UP));
    left_down_d  = ld_d & (~lu_d | (pri_l_d == PRI_DOWN));
    right_up_d   = ru_d & (~rd_d | (pri_r_d == PRI_UP));
    right_down_d = rd_d & (~ru_d | (pri_r_d == PRI_DOWN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lu_q         <= 1'b0;
      ld_q         <= 1'b0;
      ru_q         <= 1'b0;
      rd_q         <= 1'b0;
      sp_q         <= 1'b0;
      pri_l_q      <= PRI_UP;
      pri_r_q      <= PRI_UP;
      left_up_q    <= 1'b0;
      left_down_q  <= 1'b0;
      right_up_q   <= 1'b0;
      right_down_q <= 1'b0;
      start_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lu_q         <= lu_d;
      ld_q         <= ld_d;
      ru_q         <= ru_d;
      rd_q         <= rd_d;
      sp_q         <= sp_d;
      pri_l_q      <= pri_l_d;
      pri_r_q      <= pri_r_d;
      left_up_q    <= left_up_d;
      left_down_q  <= left_down_d;
      right_up_q   <= right_up_d;
      right_down_q <= right_down_d;
      start_q      <= start_d;
      err_q        <= err_d;
    end
  end

  assign left_up     = left_up_q;
  assign left_down   = left_down_q;
  assign right_up    = right_up_q;
  assign right_down  = right_down_q;
  assign start_pulse = start_q;
  assign seq_error   = err_q;

endmodule

// File: tb/tb_keyboard_pad_input.sv
// Bench for keyboard_pad_input: directed test-plan steps followed by random byte
// traffic, every cycle compared against a prefix-queue / press-time reference model.
module tb_keyboard_pad_input;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       left_up, left_down, right_up, right_down, start_pulse, seq_error;

  keyboard_pad_input #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .left_up    (left_up),
    .left_down  (left_down),
    .right_up   (right_up),
    .right_down (right_down),
    .start_pulse(start_pulse),
    .seq_error  (seq_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int unsigned r;

  // Reference model: pending prefix bytes, held keys (lu,ld,ru,rd,sp) and press times.
  logic [7:0] prefix[$];
  bit         held[5];
  longint     press_t[5];
  longint     now = 0;
  int         quiet = 0;
  bit         exp_start, exp_err;

  function automatic void model_reset();
    prefix.delete();
    for (int i = 0; i < 5; i++) begin
      held[i]    = 1'b0;
      press_t[i] = 0;
    end
    quiet = 0;
  endfunction

  function automatic int key_idx(input logic [7:0] code, input bit ext);
    if (!ext && code == 8'h1D) return 0;
    if (!ext && code == 8'h1B) return 1;
    if ( ext && code == 8'h75) return 2;
    if ( ext && code == 8'h72) return 3;
    if (!ext && code == 8'h29) return 4;
    return -1;
  endfunction

  function automatic void apply_key(input logic [7:0] code, input bit ext, input bit make);
    int k;
    k = key_idx(code, ext);
    if (k < 0) return;
    if (make) begin
      if (!held[k]) begin
        held[k]    = 1'b1;
        press_t[k] = now;
        if (k == 4) exp_start = 1'b1;
      end
    end else begin
      held[k] = 1'b0;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    bit has_e, has_f;
    has_e = 1'b0;
    has_f = 1'b0;
    foreach (prefix[i]) begin
      if (prefix[i] == 8'hE0) has_e = 1'b1;
      if (prefix[i] == 8'hF0) has_f = 1'b1;
    end
    quiet = 0;
    if (b == 8'hE0 || b == 8'hF0) begin
      if (has_f) begin
        exp_err = 1'b1;
        prefix.delete();
      end else if (!(b == 8'hE0 && has_e)) begin
        prefix.push_back(b);
      end
    end else begin
      apply_key(b, has_e, !has_f);
      prefix.delete();
    end
  endfunction

  function automatic void model_idle();
    if (prefix.size() != 0) begin
      quiet++;
      if (quiet == int'(T)) begin
        exp_err = 1'b1;
        prefix.delete();
        quiet = 0;
      end
    end
  endfunction

  function automatic logic [5:0] model_out();
    logic eu_l, ed_l, eu_r, ed_r;
    eu_l = held[0] && (!held[1] || press_t[0] > press_t[1]);
    ed_l = held[1] && (!held[0] || press_t[1] > press_t[0]);
    eu_r = held[2] && (!held[3] || press_t[2] > press_t[3]);
    ed_r = held[3] && (!held[2] || press_t[3] > press_t[2]);
    return {eu_l, ed_l, eu_r, ed_r, exp_start, exp_err};
  endfunction

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, step model at posedge, compare 1 time unit later.
  task automatic cycle(input logic rr, input logic v, input logic [7:0] b);
    logic [5:0] obs, exp;
    @(negedge clk);
    rst      = rr;
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    @(posedge clk);
    now++;
    exp_start = 1'b0;
    exp_err   = 1'b0;
    if (rr)     model_reset();
    else if (v) model_byte(b);
    else        model_idle();
    #1;
    obs = {left_up, left_down, right_up, right_down, start_pulse, seq_error};
    exp = model_out();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL outputs t=%0d observed=%b expected=%b (lu,ld,ru,rd,start,err)", now, obs, exp);
    end
    checks++;
    assert (!(left_up && left_down) && !(right_up && right_down)) else begin
      failures++;
      $error("FAIL exclusive t=%0d observed=%b expected=no up+down pair", now, obs);
    end
    if (start_pulse === 1'b1) pulses++;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b0, 1'b1, b);
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 9))
      0: return 8'h1D;
      1: return 8'h1B;
      2: return 8'h75;
      3: return 8'h72;
      4: return 8'h29;
      5, 6: return 8'hE0;
      7, 8: return 8'hF0;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    expect_bit("reset_left_up", left_up, 1'b0);
    expect_bit("reset_seq_error", seq_error, 1'b0);

    // W press / release
    send(8'h1D);
    expect_bit("w_make_left_up", left_up, 1'b1);
    send(8'hF0); send(8'h1D);
    expect_bit("w_break_left_up", left_up, 1'b0);

    // Left conflict: last pressed wins, release hands back, repeats ignored
    send(8'h1D); send(8'h1B);
    expect_bit("conflict_left_down", left_down, 1'b1);
    expect_bit("conflict_left_up", left_up, 1'b0);
    send(8'hF0); send(8'h1B);
    expect_bit("release_s_left_up", left_up, 1'b1);
    send(8'h1B);
    repeat (5) send(8'h1D);
    expect_bit("repeat_left_down", left_down, 1'b1);
    expect_bit("repeat_left_up", left_up, 1'b0);
    send(8'hF0); send(8'h1D); send(8'hF0); send(8'h1B);

    // Extended arrow up, keypad 75 ignored
    send(8'hE0); send(8'h75);
    expect_bit("arrow_up_make", right_up, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_bit("arrow_up_break", right_up, 1'b0);
    send(8'h75);
    expect_bit("keypad_75_ignored", right_up, 1'b0);

    // Space: one pulse per fresh press
    pulses = 0;
    send(8'h29); send(8'h29); send(8'h29);
    cycle(1'b0, 1'b0, 8'h00);
    checks++;
    assert (pulses == 1) else begin
      failures++;
      $error("FAIL space_repeat_pulses observed=%0d expected=1", pulses);
    end
    send(8'hF0); send(8'h29); send(8'h29);
    cycle(1'b0, 1'b0, 8'h00);
    checks++;
    assert (pulses == 2) else begin
      failures++;
      $error("FAIL space_second_press observed=%0d expected=2", pulses);
    end
    send(8'hF0); send(8'h29);

    // Timeout after a lone E0
    send(8'hE0);
    for (int i = 1; i <= int'(T); i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      expect_bit($sformatf("timeout_cycle%0d", i), seq_error, (i == int'(T)));
    end
    send(8'h72);
    expect_bit("after_timeout_72", right_down, 1'b0);

    // Protocol error and reset mid-sequence
    send(8'hF0); send(8'hE0);
    expect_bit("brk_ext_error", seq_error, 1'b1);
    send(8'hE0);
    cycle(1'b1, 1'b0, 8'h00);
    send(8'h75);
    expect_bit("reset_discards_ext", right_up, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1)       cycle(1'b1, 1'b0, 8'h00);
      else if (r < 4)  repeat ($urandom_range(10, 20)) cycle(1'b0, 1'b0, 8'h00);
      else if (r < 30) cycle(1'b0, 1'b0, 8'h00);
      else             send(pick_byte());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
